// File: rtl/bus_xfer.sv
// bus_xfer: moves one register value to another over a shared data bus.
// A transfer reads the source register for two cycles (READ, CAPT), captures
// the returned data into a holding register, and then writes it to the
// destination register (WRITE). Out-of-range register ids are rejected
// through a one-cycle ERR state.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst_n     synchronous active-low reset
//   start     transfer request, sampled only in IDLE
//   src_sel   source register id, captured with start
//   dst_sel   destination register id, captured with start
//   bus_in    read data returned by the selected source register
//   read_en   one-hot read strobes to the registers
//   write_en  one-hot write strobes to the registers
//   bus_out   write data to all registers (always the holding register)
//   busy      high in every state except IDLE
//   done      one-cycle pulse at transfer end
//   err       high together with done when the transfer was rejected
module bus_xfer #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned N_REG  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        src_sel,
  input  logic [3:0]        dst_sel,
  input  logic [DATA_W-1:0] bus_in,
  output logic [N_REG-1:0]  read_en,
  output logic [N_REG-1:0]  write_en,
  output logic [DATA_W-1:0] bus_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StCapt  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [3:0]        src_q, dst_q;
  logic [DATA_W-1:0] hold_q;
  logic              ids_ok;

  assign ids_ok = (32'(src_sel) < N_REG) && (32'(dst_sel) < N_REG);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = ids_ok ? StRead : StErr;
        end
      end
      StRead:  state_d = StCapt;
      StCapt:  state_d = StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      // Ids are latched even for rejected requests; ERR drives no strobes.
      if (state_q == StIdle && start) begin
        src_q <= src_sel;
        dst_q <= dst_sel;
      end
      if (state_q == StCapt) begin
        hold_q <= bus_in;
      end
    end
  end

  // Moore outputs: decoded from state and the latched ids only.
  always_comb begin
    read_en  = '0;
    write_en = '0;
    for (int i = 0; i < int'(N_REG); i++) begin
      if ((state_q == StRead || state_q == StCapt) && src_q == 4'(i)) begin
        read_en[i] = 1'b1;
      end
      if (state_q == StWrite && dst_q == 4'(i)) begin
        write_en[i] = 1'b1;
      end
    end
  end

  assign bus_out = hold_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone) || (state_q == StErr);
  assign err     = (state_q == StErr);

endmodule

// File: tb/tb_bus_xfer.sv
module tb_bus_xfer;

  localparam int DATA_W = 18;
  localparam int N_REG  = 12;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [3:0]        src_sel;
  logic [3:0]        dst_sel;
  logic [DATA_W-1:0] bus_in;
  logic [N_REG-1:0]  read_en;
  logic [N_REG-1:0]  write_en;
  logic [DATA_W-1:0] bus_out;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  bus_xfer #(
    .DATA_W (DATA_W),
    .N_REG  (N_REG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_sel  (src_sel),
    .dst_sel  (dst_sel),
    .bus_in   (bus_in),
    .read_en  (read_en),
    .write_en (write_en),
    .bus_out  (bus_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a timeline of expected per-cycle outputs. The front
  // entry describes the current cycle; an empty timeline means IDLE.
  typedef struct packed {
    logic [N_REG-1:0] rd;
    logic [N_REG-1:0] wr;
    logic             dn;
    logic             er;
    logic             capt;
  } ent_t;

  ent_t              exp_q[$];
  logic [DATA_W-1:0] hold_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    ent_t             e;
    logic [N_REG-1:0] one;
    one = 1;
    if (!rst_n) begin
      exp_q.delete();
      hold_m = '0;
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.capt) hold_m = bus_in;
    end else if (start) begin
      if (int'(src_sel) < N_REG && int'(dst_sel) < N_REG) begin
        exp_q.push_back('{rd: one << src_sel, wr: '0, dn: 1'b0, er: 1'b0, capt: 1'b0});
        exp_q.push_back('{rd: one << src_sel, wr: '0, dn: 1'b0, er: 1'b0, capt: 1'b1});
        exp_q.push_back('{rd: '0, wr: one << dst_sel, dn: 1'b0, er: 1'b0, capt: 1'b0});
        exp_q.push_back('{rd: '0, wr: '0, dn: 1'b1, er: 1'b0, capt: 1'b0});
      end else begin
        exp_q.push_back('{rd: '0, wr: '0, dn: 1'b1, er: 1'b1, capt: 1'b0});
      end
    end
  endtask

  task automatic check_all();
    ent_t cur;
    cur = '0;
    if (exp_q.size() != 0) cur = exp_q[0];
    chk("read_en", 64'(read_en), 64'(cur.rd));
    chk("write_en", 64'(write_en), 64'(cur.wr));
    chk("done", 64'(done), 64'(cur.dn));
    chk("err", 64'(err), 64'(cur.er));
    chk("busy", 64'(busy), 64'(exp_q.size() != 0));
    chk("bus_out", 64'(bus_out), 64'(hold_m));
    chk("read_en_onehot0", 64'($onehot0(read_en)), 64'(1));
    chk("write_en_onehot0", 64'($onehot0(write_en)), 64'(1));
    chk("strobes_exclusive", 64'((read_en != '0) && (write_en != '0)), 64'(0));
  endtask

  task automatic step(input logic s, input logic [3:0] a, input logic [3:0] b,
                      input logic [DATA_W-1:0] d, input logic r);
    start   = s;
    src_sel = a;
    dst_sel = b;
    bus_in  = d;
    rst_n   = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return DATA_W'($urandom());
  endfunction

  initial begin
    start   = 1'b0;
    src_sel = '0;
    dst_sel = '0;
    bus_in  = '0;
    rst_n   = 1'b0;

    // Reset state
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b0);
    step(1'b1, 4'd3, 4'd4, rnd_data(), 1'b0);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_bus_out", 64'(bus_out), 64'(0));

    // src=2, dst=5, accepted at the first edge out of reset
    step(1'b1, 4'd2, 4'd5, rnd_data(), 1'b1);
    chk("s1_read", 64'(read_en), 64'h004);
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);
    chk("s1_capt", 64'(read_en), 64'h004);
    step(1'b0, 4'd0, 4'd0, 18'h0000B, 1'b1);
    chk("s1_write", 64'(write_en), 64'h020);
    chk("s1_bus", 64'(bus_out), 64'h0000B);
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);
    chk("s1_done", 64'({done, err}), 64'b10);
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);

    // src == dst
    step(1'b1, 4'd3, 4'd3, rnd_data(), 1'b1);
    chk("s2_read", 64'(read_en), 64'h008);
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);
    step(1'b0, 4'd0, 4'd0, 18'h0000F, 1'b1);
    chk("s2_write", 64'(write_en), 64'h008);
    chk("s2_bus", 64'(bus_out), 64'h0000F);
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);
    chk("s2_done", 64'({done, err}), 64'b10);
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);

    // Out-of-range source id
    step(1'b1, 4'd12, 4'd0, rnd_data(), 1'b1);
    chk("s3_err", 64'({done, err}), 64'b11);
    chk("s3_strobes", 64'({read_en, write_en}), 64'(0));
    chk("s3_hold", 64'(bus_out), 64'h0000F);
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);

    // start held high: one transfer, then a new one only after an IDLE cycle
    for (int i = 0; i < 5; i++) step(1'b1, 4'd1, 4'd2, rnd_data(), 1'b1);
    chk("s4_idle_gap", 64'(busy), 64'(0));
    step(1'b1, 4'd1, 4'd2, rnd_data(), 1'b1);
    chk("s4_second", 64'(read_en), 64'h002);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);

    // Reset during CAPT aborts the transfer
    step(1'b1, 4'd1, 4'd4, rnd_data(), 1'b1);
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);
    step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b0);
    chk("s5_abort", 64'({write_en, done, busy}), 64'(0));
    chk("s5_bus", 64'(bus_out), 64'(0));
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 4'd0, rnd_data(), 1'b1);

    // Randomized traffic against the timeline model
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 13)), 4'($urandom_range(0, 13)),
           rnd_data(), ($urandom_range(0, 39) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
